// File: rtl/ras_ctrl_if.sv
// Front-end / RAS-side signal bundle for ras_ctrl.
// The slave modport is the sequencer; the master modport is the surrounding pipeline.
interface ras_ctrl_if #(
  parameter int unsigned PC_BITS = 32
);
  logic [1:0]           slot_valid;
  logic [1:0]           slot_call;
  logic [1:0]           slot_ret;
  logic [2*PC_BITS-1:0] slot_pc;
  logic                 must_flush;
  logic                 ras_empty;
  logic [PC_BITS-1:0]   ras_top;
  logic                 ras_push;
  logic                 ras_pop;
  logic [PC_BITS-1:0]   ras_new_entry;
  logic                 pred_valid;
  logic [PC_BITS-1:0]   pred_target;
  logic                 pred_slot;
  logic                 fetch_stall;

  modport master (
    output slot_valid, slot_call, slot_ret, slot_pc, must_flush, ras_empty, ras_top,
    input  ras_push, ras_pop, ras_new_entry, pred_valid, pred_target, pred_slot, fetch_stall
  );

  modport slave (
    input  slot_valid, slot_call, slot_ret, slot_pc, must_flush, ras_empty, ras_top,
    output ras_push, ras_pop, ras_new_entry, pred_valid, pred_target, pred_slot, fetch_stall
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: turns dual-slot call/ret hints into one push/pop per cycle.
// Optional RAS_CTRL_STATS_EN adds saturating push/pop/underflow counters.
module ras_ctrl #(
  parameter int unsigned PC_BITS     = 32,
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  ras_ctrl_if.slave   bus
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0] stat_push,
  output logic [31:0] stat_pop,
  output logic [31:0] stat_underflow
`endif
);

  localparam int unsigned IW = $clog2(QDEPTH);
  localparam int unsigned AW = IW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  typedef struct packed {
    logic               is_push;
    logic               tag;
    logic [PC_BITS-1:0] addr;
  } op_t;

  op_t           mem [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, count, count_nx;
  state_t        state, state_nx;

  op_t           new_op [4];
  logic [2:0]    n_new, n_enq;
  logic          enq_ok, issue_ok, deq;
  op_t           head;
  logic          push_nx, pop_nx, underflow_nx, stall_nx;

  logic               push_q, pop_q, pred_slot_q, stall_q;
  logic [PC_BITS-1:0] entry_q;

  // Pack slot ops in program order: slot 0 before slot 1, POP before PUSH within a slot.
  always_comb begin
    n_new = '0;
    for (int unsigned k = 0; k < 4; k++) new_op[k] = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (bus.slot_valid[s]) begin
        if (bus.slot_ret[s]) begin
          new_op[n_new[1:0]] = '{is_push: 1'b0, tag: 1'(s), addr: '0};
          n_new = n_new + 3'd1;
        end
        if (bus.slot_call[s]) begin
          new_op[n_new[1:0]] = '{is_push: 1'b1, tag: 1'(s),
                                 addr: bus.slot_pc[s*PC_BITS +: PC_BITS] + PC_BITS'(INSTR_BYTES)};
          n_new = n_new + 3'd1;
        end
      end
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign enq_ok   = !stall_q && !bus.must_flush && (state == RUN);
  assign n_enq    = enq_ok ? n_new : 3'd0;
  assign issue_ok = !bus.must_flush && (state != FLUSH);
  // An empty queue issues the incoming first op directly (bypass).
  assign head     = (count != '0) ? mem[rd_ptr[IW-1:0]] : new_op[0];
  assign deq      = issue_ok && ((count != '0) || (n_enq != 3'd0));

  assign push_nx      = deq && head.is_push;
  assign pop_nx       = deq && !head.is_push && !bus.ras_empty;
  assign underflow_nx = deq && !head.is_push && bus.ras_empty;

  always_comb begin
    count_nx = bus.must_flush ? '0 : count + AW'(n_enq) - AW'(deq);
    state_nx = state;
    if (bus.must_flush) begin
      state_nx = FLUSH;
    end else begin
      case (state)
        RUN:     if (n_enq == 3'd4) state_nx = DRAIN;
        DRAIN:   if (count_nx == '0) state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
    stall_nx = (state_nx != RUN) || (32'(count_nx) + 32'd4 > QDEPTH);
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (3'(k) < n_enq) mem[IW'(wr_ptr + AW'(k))] <= new_op[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      state       <= RUN;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      pred_slot_q <= 1'b0;
      entry_q     <= '0;
      stall_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      stall_q <= stall_nx;
      if (bus.must_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(n_enq);
        rd_ptr <= rd_ptr + AW'(deq);
      end
      push_q      <= push_nx;
      pop_q       <= pop_nx;
      pred_slot_q <= pop_nx ? head.tag : 1'b0;
      entry_q     <= push_nx ? head.addr : '0;
    end
  end

  assign bus.ras_push      = push_q;
  assign bus.ras_pop       = pop_q;
  assign bus.ras_new_entry = entry_q;
  assign bus.pred_valid    = pop_q;
  // The RAS pops at the end of this cycle, so its current top is the prediction.
  assign bus.pred_target   = pop_q ? bus.ras_top : '0;
  assign bus.pred_slot     = pred_slot_q;
  assign bus.fetch_stall   = stall_q;

`ifdef RAS_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_push      <= '0;
      stat_pop       <= '0;
      stat_underflow <= '0;
    end else begin
      if (push_nx && stat_push != '1)           stat_push      <= stat_push + 32'd1;
      if (pop_nx && stat_pop != '1)             stat_pop       <= stat_pop + 32'd1;
      if (underflow_nx && stat_underflow != '1) stat_underflow <= stat_underflow + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl.
module tb_ras_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ras_ctrl_if #(.PC_BITS(32)) bus ();

`ifdef RAS_CTRL_STATS_EN
  logic [31:0] stat_push, stat_pop, stat_underflow;
`endif

  ras_ctrl #(.PC_BITS(32), .QDEPTH(4), .INSTR_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RAS_CTRL_STATS_EN
    ,
    .stat_push      (stat_push),
    .stat_pop       (stat_pop),
    .stat_underflow (stat_underflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] c, input logic [1:0] r,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    bus.slot_valid = v;
    bus.slot_call  = c;
    bus.slot_ret   = r;
    bus.slot_pc    = {pc1, pc0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 32'h40, 32'h44);
    bus.must_flush = 1'b0;
    bus.ras_empty  = 1'b0;
    bus.ras_top    = 32'h0;
    tick();
    tick();
    checks++; if (bus.ras_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", bus.ras_push); end
    checks++; if (bus.ras_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", bus.ras_pop); end
    checks++; if (bus.pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", bus.pred_valid); end
    checks++; if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.fetch_stall); end
    checks++; if (bus.ras_new_entry !== 32'h0) begin errors++; $display("FAIL reset_entry: got %h want 0", bus.ras_new_entry); end
`ifdef RAS_CTRL_STATS_EN
    checks++; if (stat_push !== 32'h0) begin errors++; $display("FAIL reset_stat_push: got %0d want 0", stat_push); end
`endif
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_call();
    drive(2'b01, 2'b01, 2'b00, 32'h100, 32'h0);
    tick();
    idle();
    checks++; if (bus.ras_push !== 1'b1) begin errors++; $display("FAIL call_push: got %b want 1", bus.ras_push); end
    checks++; if (bus.ras_new_entry !== 32'h104) begin errors++; $display("FAIL call_entry: got %h want 104", bus.ras_new_entry); end
    checks++; if (bus.ras_pop !== 1'b0) begin errors++; $display("FAIL call_pop: got %b want 0", bus.ras_pop); end
    checks++; if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL call_stall: got %b want 0", bus.fetch_stall); end
    tick();
    checks++; if (bus.ras_push !== 1'b0) begin errors++; $display("FAIL call_push_end: got %b want 0", bus.ras_push); end
  endtask

  task automatic test_ret_slot1();
    bus.ras_empty = 1'b0;
    bus.ras_top   = 32'h104;
    drive(2'b10, 2'b00, 2'b10, 32'h0, 32'h180);
    tick();
    idle();
    checks++; if (bus.ras_pop !== 1'b1) begin errors++; $display("FAIL ret_pop: got %b want 1", bus.ras_pop); end
    checks++; if (bus.pred_valid !== 1'b1) begin errors++; $display("FAIL ret_pred_valid: got %b want 1", bus.pred_valid); end
    checks++; if (bus.pred_target !== 32'h104) begin errors++; $display("FAIL ret_target: got %h want 104", bus.pred_target); end
    checks++; if (bus.pred_slot !== 1'b1) begin errors++; $display("FAIL ret_slot: got %b want 1", bus.pred_slot); end
    checks++; if (bus.ras_push !== 1'b0) begin errors++; $display("FAIL ret_push: got %b want 0", bus.ras_push); end
    tick();
    checks++; if (bus.ras_pop !== 1'b0) begin errors++; $display("FAIL ret_pop_end: got %b want 0", bus.ras_pop); end
  endtask

  task automatic test_coroutine();
    logic        exp_push [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        exp_pop  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_slot [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_ent  [5] = '{32'h0, 32'h204, 32'h0, 32'h208, 32'h0};
    logic        exp_stl  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.ras_empty = 1'b0;
    bus.ras_top   = 32'h900;
    drive(2'b11, 2'b11, 2'b11, 32'h200, 32'h204);
    for (int i = 0; i < 5; i++) begin
      tick();
      idle();
      checks++; if (bus.ras_push !== exp_push[i]) begin errors++; $display("FAIL coro_push[%0d]: got %b want %b", i, bus.ras_push, exp_push[i]); end
      checks++; if (bus.ras_pop !== exp_pop[i]) begin errors++; $display("FAIL coro_pop[%0d]: got %b want %b", i, bus.ras_pop, exp_pop[i]); end
      checks++; if (bus.fetch_stall !== exp_stl[i]) begin errors++; $display("FAIL coro_stall[%0d]: got %b want %b", i, bus.fetch_stall, exp_stl[i]); end
      if (exp_push[i]) begin
        checks++; if (bus.ras_new_entry !== exp_ent[i]) begin errors++; $display("FAIL coro_entry[%0d]: got %h want %h", i, bus.ras_new_entry, exp_ent[i]); end
      end
      if (exp_pop[i]) begin
        checks++; if (bus.pred_slot !== exp_slot[i] || bus.pred_target !== 32'h900) begin errors++; $display("FAIL coro_pred[%0d]: got slot %b tgt %h want slot %b tgt 900", i, bus.pred_slot, bus.pred_target, exp_slot[i]); end
      end
    end
  endtask

  task automatic test_empty_pop();
    bus.ras_empty = 1'b1;
    drive(2'b01, 2'b00, 2'b01, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      checks++; if (bus.ras_pop !== 1'b0 || bus.pred_valid !== 1'b0) begin errors++; $display("FAIL empty_pop[%0d]: got pop %b pred %b want 0 0", i, bus.ras_pop, bus.pred_valid); end
      checks++; if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL empty_stall[%0d]: got %b want 0", i, bus.fetch_stall); end
    end
    bus.ras_empty = 1'b0;
  endtask

  task automatic test_flush();
    bus.ras_empty = 1'b0;
    drive(2'b11, 2'b11, 2'b11, 32'h700, 32'h710);
    tick();
    idle();
    checks++; if (bus.ras_pop !== 1'b1) begin errors++; $display("FAIL flush_first_pop: got %b want 1", bus.ras_pop); end
    bus.must_flush = 1'b1;
    tick();
    bus.must_flush = 1'b0;
    checks++; if (bus.ras_push !== 1'b0 || bus.ras_pop !== 1'b0 || bus.pred_valid !== 1'b0) begin errors++; $display("FAIL flush_strobes: got push %b pop %b pred %b want 0 0 0", bus.ras_push, bus.ras_pop, bus.pred_valid); end
    checks++; if (bus.fetch_stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", bus.fetch_stall); end
    tick();
    checks++; if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_release: got %b want 0", bus.fetch_stall); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ras_push !== 1'b0 || bus.ras_pop !== 1'b0) begin errors++; $display("FAIL flush_quiet[%0d]: got push %b pop %b want 0 0", i, bus.ras_push, bus.ras_pop); end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    drive(2'b11, 2'b11, 2'b11, 32'h800, 32'h810);
    tick();
    idle();
    tick();
    checks++; if (bus.ras_push !== 1'b1 || bus.ras_new_entry !== 32'h804) begin errors++; $display("FAIL rstp_push: got %b %h want 1 804", bus.ras_push, bus.ras_new_entry); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.ras_push !== 1'b0 || bus.ras_pop !== 1'b0 || bus.pred_valid !== 1'b0 || bus.ras_new_entry !== 32'h0 || bus.pred_slot !== 1'b0) begin errors++; $display("FAIL rstp_outputs: got push %b pop %b pred %b entry %h slot %b want all 0", bus.ras_push, bus.ras_pop, bus.pred_valid, bus.ras_new_entry, bus.pred_slot); end
    checks++; if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL rstp_stall: got %b want 0", bus.fetch_stall); end
    tick();
    checks++; if (bus.ras_push !== 1'b0 || bus.ras_pop !== 1'b0) begin errors++; $display("FAIL rstp_quiet: got push %b pop %b want 0 0", bus.ras_push, bus.ras_pop); end
  endtask

  task automatic test_back_to_back();
    bus.ras_top = 32'hABC;
    drive(2'b10, 2'b10, 2'b01, 32'h0, 32'hFFFF_FFFC);
    tick();
    checks++; if (bus.ras_push !== 1'b1 || bus.ras_new_entry !== 32'h0) begin errors++; $display("FAIL b2b_wrap_push: got %b %h want 1 0", bus.ras_push, bus.ras_new_entry); end
    checks++; if (bus.ras_pop !== 1'b0) begin errors++; $display("FAIL b2b_invalid_slot: got pop %b want 0", bus.ras_pop); end
    drive(2'b01, 2'b00, 2'b01, 32'h500, 32'h0);
    tick();
    idle();
    checks++; if (bus.ras_pop !== 1'b1 || bus.pred_slot !== 1'b0 || bus.pred_target !== 32'hABC) begin errors++; $display("FAIL b2b_pop: got pop %b slot %b tgt %h want 1 0 abc", bus.ras_pop, bus.pred_slot, bus.pred_target); end
    checks++; if (bus.ras_push !== 1'b0) begin errors++; $display("FAIL b2b_push_clear: got %b want 0", bus.ras_push); end
    tick();
  endtask

  initial begin
    test_reset();
    test_call();
    test_ret_slot1();
    test_coroutine();
    test_empty_pop();
    test_flush();
    test_reset_pending();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
